// File: rtl/layer_seq.sv
// layer_seq: time-multiplexed fully-connected layer.
// LANES neurons are computed in parallel per group; operands stream in one
// input index per beat, results stream out one group at a time with bias,
// fixed-point rescaling, saturation and optional ReLU applied.
module layer_seq #(
    parameter int WORD_SIZE   = 16,
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 8,
    parameter int LANES       = 4,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 2*WORD_SIZE + $clog2(NUM_INPUTS) + 1,
    localparam int GROUPS     = NUM_NEURONS / LANES,
    localparam int GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         relu_en_i,
    output logic                         busy_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WORD_SIZE-1:0]         x_i,
    input  logic [LANES*WORD_SIZE-1:0]   w_i,
    input  logic [LANES*WORD_SIZE-1:0]   bias_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [LANES*WORD_SIZE-1:0]   res_o,
    output logic [GW-1:0]                res_group_o,
    output logic                         done_o
);

    localparam int KW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_INPUTS - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    // Saturation bounds of the result word, expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        SCALE = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0]                  k_q;
    logic [GW-1:0]                  g_q;
    logic                           relu_q;
    logic [LANES*WORD_SIZE-1:0]     res_q;
    logic [GW-1:0]                  res_group_q;
    logic signed [ACC_WIDTH-1:0]    acc_q    [LANES];
    logic signed [ACC_WIDTH-1:0]    prod     [LANES];
    logic signed [ACC_WIDTH-1:0]    bias_ext [LANES];

    // Rescale one accumulator to the Q format: floor shift, clamp, optional ReLU.
    function automatic logic [WORD_SIZE-1:0] scale_lane(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic                        relu
    );
        logic signed [ACC_WIDTH-1:0] s;
        logic [WORD_SIZE-1:0]        r;
        s = acc >>> FRAC_BITS;
        if (s > SAT_MAX)
            r = SAT_MAX[WORD_SIZE-1:0];
        else if (s < SAT_MIN)
            r = SAT_MIN[WORD_SIZE-1:0];
        else
            r = s[WORD_SIZE-1:0];
        if (relu && s[ACC_WIDTH-1])
            r = '0;
        return r;
    endfunction

    // Per-lane full-precision product and bias aligned to the accumulator's binary point.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod[l]     = ACC_WIDTH'($signed(w_i[l*WORD_SIZE +: WORD_SIZE]))
                        * ACC_WIDTH'($signed(x_i));
            bias_ext[l] = ACC_WIDTH'($signed(bias_i[l*WORD_SIZE +: WORD_SIZE])) <<< FRAC_BITS;
        end
    end

    // State register.
    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode and handshake/status outputs.
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b1;
        in_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i)
                    state_d = ACCUM;
            end
            ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i && k_q == K_LAST)
                    state_d = SCALE;
            end
            SCALE: begin
                state_d = OUT;
            end
            OUT: begin
                res_valid_o = 1'b1;
                if (res_ready_i)
                    state_d = (g_q == G_LAST) ? DONE : ACCUM;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: counters, accumulators, relu flag and the result registers.
    // NOTE: the accumulator array is only LANES registers deep, so it is reset with the rest of the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q         <= '0;
            g_q         <= '0;
            relu_q      <= 1'b0;
            res_q       <= '0;
            res_group_q <= '0;
            for (int l = 0; l < LANES; l++)
                acc_q[l] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        relu_q <= relu_en_i;
                        g_q    <= '0;
                        k_q    <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        for (int l = 0; l < LANES; l++)
                            acc_q[l] <= ((k_q == '0) ? bias_ext[l] : acc_q[l]) + prod[l];
                        k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                    end
                end
                SCALE: begin
                    for (int l = 0; l < LANES; l++)
                        res_q[l*WORD_SIZE +: WORD_SIZE] <= scale_lane(acc_q[l], relu_q);
                    res_group_q <= g_q;
                end
                OUT: begin
                    if (res_ready_i && g_q != G_LAST) begin
                        g_q <= g_q + 1'b1;
                        k_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_o       = res_q;
    assign res_group_o = res_group_q;

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: directed self-checking bench for layer_seq with default parameters.
module tb_layer_seq;

    localparam int WS     = 16;
    localparam int NI     = 8;
    localparam int NN     = 8;
    localparam int LN     = 4;
    localparam int GROUPS = NN / LN;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              relu_en_i;
    logic              busy_o;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [WS-1:0]     x_i;
    logic [LN*WS-1:0]  w_i;
    logic [LN*WS-1:0]  bias_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [LN*WS-1:0]  res_o;
    logic [0:0]        res_group_o;
    logic              done_o;

    layer_seq dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .relu_en_i   (relu_en_i),
        .busy_o      (busy_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .w_i         (w_i),
        .bias_i      (bias_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .res_group_o (res_group_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cycles   = 0;

    logic [WS-1:0]    x_beats [NI];
    logic [LN*WS-1:0] w_all;
    logic [LN*WS-1:0] bias_all;
    logic [LN*WS-1:0] exp_res;

    // Count done pulses away from the active edge.
    always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_all_x(input logic [WS-1:0] v);
        for (int i = 0; i < NI; i++) x_beats[i] = v;
    endtask

    // Present beat k and hold it until a transfer edge has passed.
    task automatic send_beat(input int k, input bit gaps);
        int  n;
        bit  rdy;
        if (gaps) begin
            in_valid_i = 1'b0;
            n = $urandom_range(0, 2);
            repeat (n) begin tick(); cycles++; end
        end
        in_valid_i = 1'b1;
        x_i        = x_beats[k];
        w_i        = w_all;
        bias_i     = bias_all;
        n = 0;
        forever begin
            rdy = in_ready_o;
            tick();
            cycles++;
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("beat_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    // Wait (bounded) for res_valid_o after a group's last beat; returns edges waited.
    task automatic wait_result(output int lat);
        lat = 0;
        while (res_valid_o !== 1'b1 && lat < 20) begin
            tick();
            cycles++;
            lat++;
        end
    endtask

    task automatic run_layer(input bit relu, input bit toggle, input bit gaps,
                             input int stall, input bit mid_start);
        int d0;
        int lat;
        d0     = done_cnt;
        cycles = 0;
        start_i   = 1'b1;
        relu_en_i = relu;
        tick();
        cycles    = 1;
        start_i   = 1'b0;
        check("busy_after_start", busy_o, 1);
        if (toggle) relu_en_i = ~relu;
        for (int g = 0; g < GROUPS; g++) begin
            for (int k = 0; k < NI; k++) send_beat(k, gaps);
            check("in_ready_scale", in_ready_o, 0);
            wait_result(lat);
            check("out_latency", lat, 1);
            check("res", res_o, exp_res);
            check("res_group", res_group_o, g);
            check("in_ready_out", in_ready_o, 0);
            if (stall > 0) begin
                res_ready_i = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    if (mid_start && g == 0 && s == 1) start_i = 1'b1;
                    tick();
                    cycles++;
                    start_i = 1'b0;
                    check("stall_valid", res_valid_o, 1);
                    check("stall_res", res_o, exp_res);
                    check("stall_group", res_group_o, g);
                    check("stall_in_ready", in_ready_o, 0);
                end
                res_ready_i = 1'b1;
            end
            tick();
            cycles++;
            check("res_valid_drop", res_valid_o, 0);
        end
        check("done_pulse", done_o, 1);
        check("busy_in_done", busy_o, 1);
        if (!gaps && stall == 0) check("layer_cycles", cycles + 1, 22);
        tick();
        check("done_clear", done_o, 0);
        check("busy_idle", busy_o, 0);
        check("done_count", done_cnt - d0, 1);
        check("res_retained", res_o, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0;
        int lat;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        relu_en_i   = 1'b0;
        in_valid_i  = 1'b0;
        res_ready_i = 1'b1;
        x_i         = '0;
        w_i         = '0;
        bias_i      = '0;
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_res", res_o, 0);
        check("rst_group", res_group_o, 0);
        rst_i = 1'b0;
        tick();

        // Scenario 1: 1.0 * 1.0 summed over 8 inputs -> 8.0 per lane.
        set_all_x(16'h0100);
        w_all    = {4{16'h0100}};
        bias_all = '0;
        exp_res  = {4{16'h0800}};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Scenario 2: positive and negative saturation.
        set_all_x(16'h7FFF);
        w_all   = {4{16'h7FFF}};
        exp_res = {4{16'h7FFF}};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);
        w_all   = {4{16'h8000}};
        exp_res = {4{16'h8000}};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Scenario 3: negative result with ReLU off/on, and relu_en_i toggled mid-layer.
        set_all_x(16'h0100);
        w_all   = {4{16'hFF00}};
        exp_res = {4{16'hF800}};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);
        exp_res = '0;
        run_layer(1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_layer(1'b1, 1'b1, 1'b0, 0, 1'b0);
        exp_res = {4{16'hF800}};
        run_layer(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // Scenario 4: bias applied on beat 0, floor rounding of the half LSB.
        set_all_x(16'h0000);
        x_beats[0] = 16'h0080;
        w_all    = {4{16'h0001}};
        bias_all = {4{16'h0100}};
        exp_res  = {4{16'h0100}};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);
        bias_all = {4{16'hFF00}};
        exp_res  = {4{16'hFF00}};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Distinct lanes: lane l gets weight (l+1).0 and bias l.0 -> (9l+8).0.
        set_all_x(16'h0100);
        w_all    = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        bias_all = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
        exp_res  = {16'h2300, 16'h1A00, 16'h1100, 16'h0800};
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Scenario 5: valid gaps, 5-cycle result stall, ignored mid-layer start.
        set_all_x(16'h0100);
        w_all    = {4{16'h0100}};
        bias_all = '0;
        exp_res  = {4{16'h0800}};
        run_layer(1'b0, 1'b0, 1'b1, 5, 1'b1);

        // Scenario 6: reset during group 1 accumulation abandons the layer.
        d0        = done_cnt;
        start_i   = 1'b1;
        relu_en_i = 1'b0;
        tick();
        start_i   = 1'b0;
        for (int k = 0; k < NI; k++) send_beat(k, 1'b0);
        wait_result(lat);
        check("r6_group0_res", res_o, exp_res);
        tick();
        for (int k = 0; k < 3; k++) send_beat(k, 1'b0);
        in_valid_i = 1'b1;
        #2;
        rst_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("r6_busy", busy_o, 0);
        check("r6_in_ready", in_ready_o, 0);
        check("r6_res_valid", res_valid_o, 0);
        check("r6_res", res_o, 0);
        check("r6_group", res_group_o, 0);
        check("r6_done", done_o, 0);
        rst_i = 1'b0;
        tick();
        tick();
        check("r6_no_done", done_cnt - d0, 0);
        check("r6_idle", busy_o, 0);
        run_layer(1'b0, 1'b0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
